// File: rtl/demod_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | demod_pkg : shared types/constants for the AM/ASK demodulator scheduler  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package demod_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_AM  = 2'd1,
        RUN_ASK = 2'd2,
        FLUSH   = 2'd3
    } mode_e;

    localparam int WIN_CNT_W = 16;

    // Mode bit encoding, also used by am_ask_demod
    localparam logic MODE_AM  = 1'b0;
    localparam logic MODE_ASK = 1'b1;

    function automatic mode_e run_state(input logic mode);
        return (mode == MODE_ASK) ? RUN_ASK : RUN_AM;
    endfunction

endpackage : demod_pkg
`default_nettype wire

// File: rtl/low_level_window.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | low_level_window : counts near-zero samples over fixed sample windows    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module low_level_window
    import demod_pkg::*;
#(
    parameter int AD_WIDTH            = 10,
    parameter int SAMPLE_COUNT        = 10000,
    parameter int LOW_LEVEL_THRESHOLD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [AD_WIDTH-1:0]  ad_data,
    output logic                 win_done,
    output logic [WIN_CNT_W-1:0] win_low_count
);

    localparam int SMP_W = $clog2(SAMPLE_COUNT);
    localparam logic [SMP_W-1:0]     c_last_smp = SMP_W'(SAMPLE_COUNT - 1);
    localparam logic [31:0]          c_low_thr  = 32'(LOW_LEVEL_THRESHOLD);
    localparam logic [WIN_CNT_W-1:0] c_sat      = {WIN_CNT_W{1'b1}};

    logic [SMP_W-1:0]     r_smp_cnt;
    logic [WIN_CNT_W-1:0] r_low_cnt;
    logic [WIN_CNT_W-1:0] r_win_low;
    logic                 r_win_done;
    logic                 w_is_low;
    logic [WIN_CNT_W-1:0] w_low_next;

    assign w_is_low   = (32'(ad_data) < c_low_thr);
    assign w_low_next = (w_is_low && (r_low_cnt != c_sat)) ? (r_low_cnt + WIN_CNT_W'(1))
                                                           : r_low_cnt;

    // The closing sample is folded into the reported count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_cnt  <= '0;
            r_low_cnt  <= '0;
            r_win_low  <= '0;
            r_win_done <= 1'b0;
        end else begin
            r_win_done <= 1'b0;
            if (sample_valid) begin
                if (r_smp_cnt == c_last_smp) begin
                    r_smp_cnt  <= '0;
                    r_low_cnt  <= '0;
                    r_win_low  <= w_low_next;
                    r_win_done <= 1'b1;
                end else begin
                    r_smp_cnt <= r_smp_cnt + SMP_W'(1);
                    r_low_cnt <= w_low_next;
                end
            end
        end
    end

    assign win_done      = r_win_done;
    assign win_low_count = r_win_low;

endmodule : low_level_window
`default_nettype wire

// File: rtl/demod_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | demod_mode_ctrl : votes AM vs ASK per window, switches with FIR flush    |
// | Optional DEMOD_MODE_FORCE_EN adds force_en/force_ask override.  Rev 1.0  |
// +--------------------------------------------------------------------------+
module demod_mode_ctrl
    import demod_pkg::*;
#(
    parameter int AD_WIDTH            = 10,
    parameter int SAMPLE_COUNT        = 10000,
    parameter int LOW_LEVEL_THRESHOLD = 10,
    parameter int ASK_THRESHOLD       = 2000,
    parameter int CONFIRM_WINDOWS     = 2,
    parameter int FLUSH_CYCLES        = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    input  logic [AD_WIDTH-1:0]  ad_data,
`ifdef DEMOD_MODE_FORCE_EN
    input  logic                 force_en,
    input  logic                 force_ask,
`endif
    output logic                 am_en,
    output logic                 ask_en,
    output logic                 is_ask,
    output logic                 type_valid,
    output logic                 mode_change,
    output logic                 win_done,
    output logic [WIN_CNT_W-1:0] win_low_count
);

    localparam int DIS_W   = $clog2(CONFIRM_WINDOWS + 1);
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DIS_W-1:0]     c_confirm    = DIS_W'(CONFIRM_WINDOWS);
    localparam logic [FLUSH_W-1:0]   c_flush_last = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [WIN_CNT_W:0]   c_ask_thr    = (WIN_CNT_W + 1)'(ASK_THRESHOLD);

    logic                 w_win_done;
    logic [WIN_CNT_W-1:0] w_win_low;
    logic                 w_vote_ask;
    logic                 w_force_en;
    logic                 w_force_ask;

    mode_e                r_state,       w_state;
    logic [DIS_W-1:0]     r_disagree,    w_disagree;
    logic [FLUSH_W-1:0]   r_flush_cnt,   w_flush_cnt;
    logic                 r_target,      w_target;
    logic                 r_is_ask,      w_is_ask;
    logic                 r_type_valid,  w_type_valid;
    logic                 r_mode_change, w_mode_change;
    logic [DIS_W-1:0]     w_dis_inc;

    low_level_window #(
        .AD_WIDTH            (AD_WIDTH),
        .SAMPLE_COUNT        (SAMPLE_COUNT),
        .LOW_LEVEL_THRESHOLD (LOW_LEVEL_THRESHOLD)
    ) u_window (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .ad_data       (ad_data),
        .win_done      (w_win_done),
        .win_low_count (w_win_low)
    );

`ifdef DEMOD_MODE_FORCE_EN
    assign w_force_en  = force_en;
    assign w_force_ask = force_ask;
`else
    assign w_force_en  = 1'b0;
    assign w_force_ask = 1'b0;
`endif

    assign w_vote_ask = ({1'b0, w_win_low} > c_ask_thr);
    assign w_dis_inc  = r_disagree + DIS_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_disagree    <= '0;
            r_flush_cnt   <= '0;
            r_target      <= MODE_AM;
            r_is_ask      <= 1'b0;
            r_type_valid  <= 1'b0;
            r_mode_change <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_disagree    <= w_disagree;
            r_flush_cnt   <= w_flush_cnt;
            r_target      <= w_target;
            r_is_ask      <= w_is_ask;
            r_type_valid  <= w_type_valid;
            r_mode_change <= w_mode_change;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_disagree    = r_disagree;
        w_flush_cnt   = r_flush_cnt;
        w_target      = r_target;
        w_is_ask      = r_is_ask;
        w_type_valid  = r_type_valid;
        w_mode_change = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_force_en) begin
                    w_state       = run_state(w_force_ask);
                    w_is_ask      = w_force_ask;
                    w_type_valid  = 1'b1;
                    w_mode_change = 1'b1;
                end else if (w_win_done) begin
                    w_state       = run_state(w_vote_ask);
                    w_is_ask      = w_vote_ask;
                    w_type_valid  = 1'b1;
                    w_mode_change = 1'b1;
                end
            end
            RUN_AM, RUN_ASK: begin
                if (w_force_en) begin
                    w_disagree = '0;
                    if (w_force_ask != r_is_ask) begin
                        w_state     = FLUSH;
                        w_target    = w_force_ask;
                        w_flush_cnt = '0;
                    end
                end else if (w_win_done) begin
                    if (w_vote_ask == r_is_ask) begin
                        w_disagree = '0;
                    end else if (w_dis_inc == c_confirm) begin
                        w_state     = FLUSH;
                        w_target    = w_vote_ask;
                        w_disagree  = '0;
                        w_flush_cnt = '0;
                    end else begin
                        w_disagree = w_dis_inc;
                    end
                end
            end
            FLUSH: begin
                // An active override may retarget a flush already in progress
                if (w_force_en) begin
                    w_target   = w_force_ask;
                    w_disagree = '0;
                end
                if (r_flush_cnt == c_flush_last) begin
                    w_state       = run_state(w_target);
                    w_is_ask      = w_target;
                    w_mode_change = 1'b1;
                    w_flush_cnt   = '0;
                end else begin
                    w_flush_cnt = r_flush_cnt + FLUSH_W'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign am_en         = (r_state == RUN_AM);
    assign ask_en        = (r_state == RUN_ASK);
    assign is_ask        = r_is_ask;
    assign type_valid    = r_type_valid;
    assign mode_change   = r_mode_change;
    assign win_done      = w_win_done;
    assign win_low_count = w_win_low;

endmodule : demod_mode_ctrl
`default_nettype wire
